// File: rtl/pipe_pkg.sv
// Shared types for the handshaked pipeline stage register.
//   ps_state_e : stage fill state (EMPTY / ONE / FULL)
//   OCC_W      : width of the occupancy count (0..2)
//   occ_of()   : number of entries held in a given state
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } ps_state_e;

    function automatic logic [OCC_W-1:0] occ_of(input ps_state_e s);
        case (s)
            PS_ONE:  return OCC_W'(1);
            PS_FULL: return OCC_W'(2);
            default: return OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating statistics counters for one pipeline stage.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   stall_inc      1 = add one stall cycle this edge
//   flush_add      entries discarded by flush this edge (0..2)
//   stall_cnt      saturating stall-cycle count
//   flush_cnt      saturating discarded-entry count
module pipe_stage_stats
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic [OCC_W-1:0] flush_add,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned SUM_W = CNT_W + OCC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] stall_d;
    logic [CNT_W-1:0] flush_d;

    // Add with clamp at all-ones; the sum is widened so it cannot wrap.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [OCC_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(inc);
        if (sum > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return sum[CNT_W-1:0];
    endfunction

    always_comb begin
        stall_d = sat_add(stall_q, OCC_W'(stall_inc));
        flush_d = sat_add(flush_q, flush_add);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a two-entry skid buffer.
// The main entry drives out_data; the skid entry absorbs the one beat that
// can arrive while in_ready is being withdrawn, so in_ready is registered and
// no input reaches any output combinationally. flush empties the stage.
// Optional feature: define PIPE_STAGE_STATS_EN to add stall_cnt/flush_cnt.
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   flush                  discard all held entries this cycle
//   in_valid/in_ready      upstream handshake (in_ready registered)
//   in_data                upstream payload, DATA_W bits
//   out_valid/out_ready    downstream handshake
//   out_data               payload from the main entry
//   occupancy              entries held (0..2)
//   stall_cnt, flush_cnt   statistics (PIPE_STAGE_STATS_EN only)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned CLEAR_ON_FLUSH = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Elaboration-time guard on parameter ranges.
    if (DATA_W == 0 || CNT_W == 0) begin : g_param_check
        $error("pipe_stage_reg: DATA_W and CNT_W must be at least 1");
    end

    ps_state_e         state_q;
    ps_state_e         state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [OCC_W-1:0]  occ_q;

    logic              accept_c;
    logic              pop_c;

    // Handshakes are qualified only by registered flags.
    assign accept_c = in_valid & in_ready_q;
    assign pop_c    = out_valid_q & out_ready;

    // Next-state and payload steering; main always holds the oldest entry.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            PS_EMPTY: begin
                if (accept_c) begin
                    main_d  = in_data;
                    state_d = PS_ONE;
                end
            end
            PS_ONE: begin
                if (accept_c && pop_c) begin
                    main_d = in_data;
                end else if (accept_c) begin
                    skid_d  = in_data;
                    state_d = PS_FULL;
                end else if (pop_c) begin
                    state_d = PS_EMPTY;
                end
            end
            PS_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop_c) begin
                    main_d  = skid_q;
                    state_d = PS_ONE;
                end
            end
            default: begin
                state_d = PS_EMPTY;
            end
        endcase

        // Flush overrides everything, including a same-cycle accept.
        if (flush) begin
            state_d = PS_EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end
    end

    // State, payloads and output flags; flags are precomputed from state_d.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= PS_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != PS_FULL);
            out_valid_q <= (state_d != PS_EMPTY);
            occ_q       <= occ_of(state_d);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

`ifdef PIPE_STAGE_STATS_EN
    logic             stall_inc_c;
    logic [OCC_W-1:0] flush_add_c;

    // Entries lost to flush exclude one that completed downstream this cycle.
    always_comb begin
        stall_inc_c = out_valid_q & ~out_ready;
        flush_add_c = '0;
        if (flush) begin
            flush_add_c = occ_q - OCC_W'(pop_c);
        end
    end

    pipe_stage_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk       (clk),
        .rst       (rst),
        .stall_inc (stall_inc_c),
        .flush_add (flush_add_c),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg. Two instances share the
// same stimulus: u_dut clears payloads on flush, u_keep retains them and uses
// a 2-bit counter width so saturation is reachable.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready,  k_in_ready;
    logic        out_valid, k_out_valid;
    logic [31:0] out_data,  k_out_data;
    logic [1:0]  occ,       k_occ;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  k_stall_cnt, k_flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1), .CNT_W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occ)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(0), .CNT_W(2)) u_keep (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (k_in_ready),
        .in_data   (in_data),
        .out_valid (k_out_valid),
        .out_ready (out_ready),
        .out_data  (k_out_data),
        .occupancy (k_occ)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (k_stall_cnt),
        .flush_cnt (k_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        #1;

        // Reset held two edges with a valid beat offered.
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_occ",       32'(occ),       32'd0);
`ifdef PIPE_STAGE_STATS_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif

        // First edge after release: offered beat is refused, in_ready rises.
        rst = 1'b1;
        step();
        chk("rel_in_ready",  32'(in_ready),  32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // Streaming 1..8 with out_ready high.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            step();
            chk("stream_data",  out_data,        32'(i));
            chk("stream_valid", 32'(out_valid),  32'd1);
            chk("stream_occ",   32'(occ),        32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain_valid", 32'(out_valid), 32'd0);
        chk("stream_drain_occ",   32'(occ),       32'd0);

        // Back-pressure: A then B fill the stage, C waits upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        chk("bp_a_occ",      32'(occ),      32'd1);
        chk("bp_a_in_ready", 32'(in_ready), 32'd1);
        in_data = 32'hB;
        step();
        chk("bp_full_occ",      32'(occ),      32'd2);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_full_data",     out_data,      32'hA);
        in_data = 32'hC;
        step();
        step();
        chk("bp_hold_data", out_data, 32'hA);
        chk("bp_hold_occ",  32'(occ), 32'd2);
`ifdef PIPE_STAGE_STATS_EN
        chk("bp_stall_cnt",   32'(stall_cnt),   32'd3);
        chk("bp_k_stall_cnt", 32'(k_stall_cnt), 32'd3);
`endif
        out_ready = 1'b1;
        step();
        chk("bp_out_b",      out_data,      32'hB);
        chk("bp_b_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_out_c", out_data, 32'hC);
        chk("bp_c_occ", 32'(occ), 32'd1);
        in_valid = 1'b0;
        step();
        chk("bp_drain_valid", 32'(out_valid), 32'd0);

        // Hold one entry stalled for 5 cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("stall_hold_data", out_data, 32'h11);
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_cnt_5",     32'(stall_cnt),   32'd8);
        chk("stall_k_sat",     32'(k_stall_cnt), 32'd3);
`endif

        // Fill to FULL, then flush with 0xE offered.
        in_valid = 1'b1;
        in_data  = 32'h12;
        step();
        chk("pre_flush_occ", 32'(occ), 32'd2);
        flush   = 1'b1;
        in_data = 32'hE;
        step();
        chk("flush_valid",    32'(out_valid),   32'd0);
        chk("flush_occ",      32'(occ),         32'd0);
        chk("flush_data_clr", out_data,         32'd0);
        chk("flush_k_valid",  32'(k_out_valid), 32'd0);
        chk("flush_k_data",   k_out_data,       32'h11);
        chk("flush_in_ready", 32'(in_ready),    32'd1);
`ifdef PIPE_STAGE_STATS_EN
        chk("flush_cnt_2",    32'(flush_cnt),   32'd2);
        chk("flush_k_cnt_2",  32'(k_flush_cnt), 32'd2);
        chk("flush_stall",    32'(stall_cnt),   32'd10);
`endif
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_flush_valid", 32'(out_valid), 32'd0);
        chk("post_flush_data",  out_data,       32'd0);

        // Flush coinciding with a pop: the popped entry is not counted as lost.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h21;
        step();
        chk("pf_load_data", out_data, 32'h21);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        chk("pf_valid",  32'(out_valid), 32'd0);
        chk("pf_data",   out_data,       32'd0);
        chk("pf_k_data", k_out_data,     32'h21);
`ifdef PIPE_STAGE_STATS_EN
        chk("pf_flush_cnt", 32'(flush_cnt), 32'd2);
        chk("pf_stall_cnt", 32'(stall_cnt), 32'd10);
`endif
        flush = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register for the processor datapath, generalising the fixed per-field stage latches between IF/ID/EXE/MEM/WB. Carries an opaque payload of DATA_W bits with valid/ready flow control, absorbs one cycle of downstream back-pressure in a two-entry skid buffer so that in_ready is registered, and supports a synchronous flush that turns the stage into a zero bubble. Each pipeline boundary instantiates this block with the payload packed from its control and data fields.

## Interface
- DATA_W, 32: payload width in bits (≥1).
- CLEAR_ON_FLUSH, 1: 1 = payload registers zeroed on flush; 0 = only valid bits cleared.
- CNT_W, 16: statistics counter width (used only with PIPE_STAGE_STATS_EN).

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  discard all held entries this cycle.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload, driven from main entry.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  stats only: cycles with out_valid & !out_ready.
- flush_cnt  out  CNT_W  stats only: entries discarded by flush.

## Operation
- Storage: main entry (drives out_data) and skid entry, each with payload register.
- States: EMPTY (occupancy 0), ONE (main valid), FULL (main + skid valid).
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (state != FULL), registered; out_valid = (state != EMPTY).
- EMPTY: accept → ONE, main ← in_data.
- ONE: accept & pop → ONE, main ← in_data; accept & !pop → FULL, skid ← in_data; pop & !accept → EMPTY.
- FULL: no accept possible; pop → ONE, main ← skid.
- Order preserved: main always holds the oldest entry.
- Flush (rst high, flush high): next state EMPTY, in_valid that cycle discarded, pop that cycle still counts as completed downstream; CLEAR_ON_FLUSH=1 zeroes both payload registers.
- Reset (rst low): state EMPTY, in_ready 0 during reset, 1 the first cycle after release; payloads 0; counters 0. Reset beats flush.

## Timing
- Latency: in_data accepted at edge N visible on out_data after edge N (1 cycle) when EMPTY or popping.
- Throughput: 1 entry/cycle with out_ready held high.
- in_ready falls the cycle after entering FULL; the skid absorbs the one in-flight beat, so upstream may drive in_ready-qualified valid without combinational path from out_ready.
- No combinational path from in_valid/in_data/out_ready to any output.
- out_data stable while out_valid & !out_ready.
- Reset outputs: out_valid 0, out_data 0, occupancy 0, in_ready 0, stall_cnt 0, flush_cnt 0.

## Configuration
- PIPE_STAGE_STATS_EN defined: stall_cnt and flush_cnt ports and counters present; both saturate at 2^CNT_W−1; flush_cnt adds occupancy minus any same-cycle pop (0..2).
- Undefined: ports and counters omitted; datapath behaviour identical.

## Structure
- Package pipe_pkg: stage state enum (PS_EMPTY, PS_ONE, PS_FULL) and occupancy width constant.
- Sub-module pipe_stage_stats: saturating counters, instantiated only under PIPE_STAGE_STATS_EN.
- Storage and FSM inline in pipe_stage_reg.

## Test plan
- Reset: rst low 2 cycles with in_valid=1, in_data=0xDEADBEEF → out_valid 0, out_data 0, in_ready 0; one cycle after release in_ready 1.
- Streaming: out_ready=1, push 0x1..0x8 back-to-back → out_data 0x1..0x8 one cycle later each, occupancy never 2.
- Back-pressure: out_ready=0, push 0xA, 0xB → FULL, in_ready 0, 0xC held upstream; raise out_ready → outputs 0xA, 0xB, 0xC in order, no loss or duplicate.
- Flush while FULL with in_valid=1 (0xE): next cycle out_valid 0, occupancy 0, out_data 0 (CLEAR_ON_FLUSH=1); 0xE never appears; flush_cnt +2.
- Flush with CLEAR_ON_FLUSH=0: out_valid 0, out_data retains prior value.
- Stats: out_ready=0 for 5 cycles with occupancy>0 → stall_cnt 5; CNT_W=2 forced saturation → stall_cnt sticks at 3.
